// File: rtl/puck_physics_ctl_if.sv
// Signal bundle between puck_physics_ctl and its neighbours.
//   master : frame pacing and player positions in; puck position, scores,
//            goal pulses and rally state out (player controllers / draw side).
//   slave  : the physics controller itself.
// Positions are 12-bit unsigned pixel coordinates; scores saturate at 15.
interface puck_physics_ctl_if;
  logic        frame_tick;
  logic [11:0] xpos_player_1;
  logic [11:0] ypos_player_1;
  logic [11:0] xpos_player_2;
  logic [11:0] ypos_player_2;
  logic [11:0] xpos_ball;
  logic [11:0] ypos_ball;
  logic [3:0]  score_p1;
  logic [3:0]  score_p2;
  logic        goal_p1;
  logic        goal_p2;
  logic [1:0]  game_state;

  modport master (
    output frame_tick, xpos_player_1, ypos_player_1, xpos_player_2, ypos_player_2,
    input  xpos_ball, ypos_ball, score_p1, score_p2, goal_p1, goal_p2, game_state
  );

  modport slave (
    input  frame_tick, xpos_player_1, ypos_player_1, xpos_player_2, ypos_player_2,
    output xpos_ball, ypos_ball, score_p1, score_p2, goal_p1, goal_p2, game_state
  );
endinterface

// File: rtl/puck_physics_ctl.sv
// Air-hockey puck physics and rally sequencer.
// Moves the puck by a signed 4-bit velocity once per frame_tick, bounces it
// off the field walls, redirects it on mallet hits (player 1 has priority),
// detects goals in both end-wall mouths and keeps a saturating score.
// Rally sequence: SERVE (puck centred) -> PLAY -> GOAL (puck frozen) -> SERVE.
// Ports:
//   clk_in, rst : clock, synchronous active-high reset
//   bus (slave) : frame_tick, player positions in; puck position, scores,
//                 one-cycle goal pulses and game_state (0 SERVE,1 PLAY,2 GOAL) out
// Build option: define PUCK_FRICTION_EN to decay each velocity component by
// one every FRICTION_TICKS frames while in PLAY (not on hit frames).
module puck_physics_ctl #(
  parameter int RADIUS_BALL    = 10,
  parameter int PLAYERS_RADIUS = 20,
  parameter int FIELD_X_MIN    = 44,
  parameter int FIELD_X_MAX    = 979,
  parameter int FIELD_Y_MIN    = 44,
  parameter int FIELD_Y_MAX    = 735,
  parameter int GOAL_Y_MIN     = 312,
  parameter int GOAL_Y_MAX     = 412,
  parameter int X_START        = 487,
  parameter int Y_START        = 362,
  parameter int MAX_SPEED      = 4,
  parameter int SERVE_DELAY    = 60,
  parameter int FRICTION_TICKS = 16
) (
  input  logic               clk_in,
  input  logic               rst,
  puck_physics_ctl_if.slave  bus
);

  typedef enum logic [1:0] {S_SERVE = 2'd0, S_PLAY = 2'd1, S_GOAL = 2'd2} state_t;

  localparam int CNT_W = $clog2(SERVE_DELAY + 1);
  localparam logic signed [12:0] R_S     = 13'(RADIUS_BALL);
  localparam logic signed [13:0] HIT_S   = 14'(RADIUS_BALL + PLAYERS_RADIUS);
  localparam logic signed [12:0] FXMIN_S = 13'(FIELD_X_MIN);
  localparam logic signed [12:0] FXMAX_S = 13'(FIELD_X_MAX);
  localparam logic signed [12:0] FYMIN_S = 13'(FIELD_Y_MIN);
  localparam logic signed [12:0] FYMAX_S = 13'(FIELD_Y_MAX);
  localparam logic signed [12:0] GYMIN_S = 13'(GOAL_Y_MIN);
  localparam logic signed [12:0] GYMAX_S = 13'(GOAL_Y_MAX);
  localparam logic signed [3:0]  MAX_S   = 4'(MAX_SPEED);

  function automatic logic signed [3:0] abs4(input logic signed [3:0] v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic signed [12:0] ext4(input logic signed [3:0] v);
    return {{9{v[3]}}, v};
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  // Within reach on one axis: |a-b| <= puck radius + mallet radius.
  function automatic logic near(input logic signed [12:0] a, input logic signed [12:0] b);
    logic signed [13:0] d;
    d = 14'(a) - 14'(b);
    return ((d < 0) ? -d : d) <= HIT_S;
  endfunction

  // Away from the mallet at full speed; dead-centre reflects the axis.
  function automatic logic signed [3:0] hit_vel(input logic signed [12:0] n,
                                                input logic signed [12:0] p,
                                                input logic signed [3:0]  v);
    if (n > p)      return MAX_S;
    else if (n < p) return -MAX_S;
    else            return -v;
  endfunction

`ifdef PUCK_FRICTION_EN
  localparam int FCNT_W = $clog2(FRICTION_TICKS + 1);

  function automatic logic signed [3:0] toward_zero(input logic signed [3:0] v);
    if (v > 0)      return v - 4'sd1;
    else if (v < 0) return v + 4'sd1;
    else            return v;
  endfunction

  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
`endif

  state_t             state_q, state_d;
  logic [11:0]        x_q, x_d, y_q, y_d;
  logic signed [3:0]  vx_q, vx_d, vy_q, vy_d;
  logic [3:0]         s1_q, s1_d, s2_q, s2_d;
  logic               goal1_q, goal1_d, goal2_q, goal2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic signed [12:0] xc, yc, nx, ny, px, py;
  logic signed [12:0] xp1, yp1, xp2, yp2;
  logic signed [3:0]  nvx, nvy;
  logic               hit1, hit2, in_mouth;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    cnt_d   = cnt_q;
    goal1_d = 1'b0;
    goal2_d = 1'b0;
`ifdef PUCK_FRICTION_EN
    fcnt_d  = fcnt_q;
`endif
    xc  = $signed({1'b0, x_q});
    yc  = $signed({1'b0, y_q});
    nx  = xc + ext4(vx_q);
    ny  = yc + ext4(vy_q);
    xp1 = $signed({1'b0, bus.xpos_player_1});
    yp1 = $signed({1'b0, bus.ypos_player_1});
    xp2 = $signed({1'b0, bus.xpos_player_2});
    yp2 = $signed({1'b0, bus.ypos_player_2});
    hit1     = near(nx, xp1) && near(ny, yp1);
    hit2     = near(nx, xp2) && near(ny, yp2);
    in_mouth = (ny >= GYMIN_S) && (ny <= GYMAX_S);
    px  = nx;
    py  = ny;
    nvx = vx_q;
    nvy = vy_q;

    if (bus.frame_tick) begin
      case (state_q)
        S_SERVE: begin
          x_d  = 12'(X_START);
          y_d  = 12'(Y_START);
          vx_d = '0;
          vy_d = '0;
          if (cnt_q == CNT_W'(SERVE_DELAY - 1)) begin
            state_d = S_PLAY;
            cnt_d   = '0;
`ifdef PUCK_FRICTION_EN
            fcnt_d  = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_PLAY: begin
          if ((nx - R_S <= FXMIN_S) && in_mouth) begin
            s2_d    = sat_inc(s2_q);
            goal2_d = 1'b1;
            vx_d    = '0;
            vy_d    = '0;
            cnt_d   = '0;
            state_d = S_GOAL;
          end else if ((nx + R_S >= FXMAX_S) && in_mouth) begin
            s1_d    = sat_inc(s1_q);
            goal1_d = 1'b1;
            vx_d    = '0;
            vy_d    = '0;
            cnt_d   = '0;
            state_d = S_GOAL;
          end else begin
            if (hit1) begin
              nvx = hit_vel(nx, xp1, vx_q);
              nvy = hit_vel(ny, yp1, vy_q);
              px  = xc + ext4(nvx);
              py  = yc + ext4(nvy);
            end else if (hit2) begin
              nvx = hit_vel(nx, xp2, vx_q);
              nvy = hit_vel(ny, yp2, vy_q);
              px  = xc + ext4(nvx);
              py  = yc + ext4(nvy);
            end
`ifdef PUCK_FRICTION_EN
            // This frame already moved at the old speed; decay affects the next one.
            if (fcnt_q == FCNT_W'(FRICTION_TICKS - 1)) begin
              fcnt_d = '0;
              if (!hit1 && !hit2) begin
                nvx = toward_zero(nvx);
                nvy = toward_zero(nvy);
              end
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
`endif
            // Clamp one pixel inside the wall so the next frame cannot re-trigger.
            if (px - R_S <= FXMIN_S) begin
              px  = FXMIN_S + R_S + 13'sd1;
              nvx = abs4(nvx);
            end else if (px + R_S >= FXMAX_S) begin
              px  = FXMAX_S - R_S - 13'sd1;
              nvx = -abs4(nvx);
            end
            if (py - R_S <= FYMIN_S) begin
              py  = FYMIN_S + R_S + 13'sd1;
              nvy = abs4(nvy);
            end else if (py + R_S >= FYMAX_S) begin
              py  = FYMAX_S - R_S - 13'sd1;
              nvy = -abs4(nvy);
            end
            x_d  = px[11:0];
            y_d  = py[11:0];
            vx_d = nvx;
            vy_d = nvy;
          end
        end

        S_GOAL: begin
          if (cnt_q == CNT_W'(SERVE_DELAY - 1)) begin
            state_d = S_SERVE;
            cnt_d   = '0;
            x_d     = 12'(X_START);
            y_d     = 12'(Y_START);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: state_d = S_SERVE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= S_SERVE;
      x_q     <= 12'(X_START);
      y_q     <= 12'(Y_START);
      vx_q    <= '0;
      vy_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      goal1_q <= 1'b0;
      goal2_q <= 1'b0;
      cnt_q   <= '0;
`ifdef PUCK_FRICTION_EN
      fcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      goal1_q <= goal1_d;
      goal2_q <= goal2_d;
      cnt_q   <= cnt_d;
`ifdef PUCK_FRICTION_EN
      fcnt_q  <= fcnt_d;
`endif
    end
  end

  assign bus.xpos_ball  = x_q;
  assign bus.ypos_ball  = y_q;
  assign bus.score_p1   = s1_q;
  assign bus.score_p2   = s2_q;
  assign bus.goal_p1    = goal1_q;
  assign bus.goal_p2    = goal2_q;
  assign bus.game_state = state_q;

endmodule

// File: tb/tb_puck_physics_ctl.sv
// Directed bench for puck_physics_ctl: serve timing, mallet hits and priority,
// wall bounces, both goals with pulse width and score, reset during GOAL.
// With PUCK_FRICTION_EN defined it runs the reset and friction scenarios.
module tb_puck_physics_ctl;
  logic clk_in = 1'b0;
  logic rst    = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  puck_physics_ctl_if bus ();

  puck_physics_ctl dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic do_tick();
    @(negedge clk_in);
    bus.frame_tick = 1'b1;
    @(posedge clk_in);
    #1;
    bus.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst = 1'b1;
    @(posedge clk_in);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_players(input int x1, input int y1, input int x2, input int y2);
    bus.xpos_player_1 = 12'(x1);
    bus.ypos_player_1 = 12'(y1);
    bus.xpos_player_2 = 12'(x2);
    bus.ypos_player_2 = 12'(y2);
  endtask

  task automatic to_play();
    set_players(1500, 1500, 1500, 1500);
    do_reset();
    ticks(60);
  endtask

  task automatic test_reset();
    set_players(1500, 1500, 1500, 1500);
    do_reset();
    checks++; if (bus.game_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", bus.game_state); end
    checks++; if (bus.xpos_ball !== 12'd487 || bus.ypos_ball !== 12'd362) begin failures++; $display("FAIL rst_pos got=(%0d,%0d) exp=(487,362)", bus.xpos_ball, bus.ypos_ball); end
    checks++; if (bus.score_p1 !== 4'd0 || bus.score_p2 !== 4'd0) begin failures++; $display("FAIL rst_score got=%0d/%0d exp=0/0", bus.score_p1, bus.score_p2); end
    checks++; if (bus.goal_p1 !== 1'b0 || bus.goal_p2 !== 1'b0) begin failures++; $display("FAIL rst_goal got=%0b%0b exp=00", bus.goal_p1, bus.goal_p2); end
    // Mallet sitting on the puck during SERVE must not move it.
    set_players(487, 362, 1500, 1500);
    ticks(59);
    checks++; if (bus.game_state !== 2'd0) begin failures++; $display("FAIL serve59_state got=%0d exp=0", bus.game_state); end
    checks++; if (bus.xpos_ball !== 12'd487 || bus.ypos_ball !== 12'd362) begin failures++; $display("FAIL serve59_pos got=(%0d,%0d) exp=(487,362)", bus.xpos_ball, bus.ypos_ball); end
    ticks(1);
    checks++; if (bus.game_state !== 2'd1) begin failures++; $display("FAIL serve60_state got=%0d exp=1", bus.game_state); end
    checks++; if (bus.score_p1 !== 4'd0 || bus.score_p2 !== 4'd0) begin failures++; $display("FAIL serve60_score got=%0d/%0d exp=0/0", bus.score_p1, bus.score_p2); end
  endtask

`ifdef PUCK_FRICTION_EN
  task automatic test_friction();
    to_play();
    set_players(467, 362, 1500, 1500);
    ticks(1);
    set_players(1500, 1500, 1500, 1500);
    checks++; if (bus.xpos_ball !== 12'd491) begin failures++; $display("FAIL fr_hit_x got=%0d exp=491", bus.xpos_ball); end
    ticks(15);
    checks++; if (bus.xpos_ball !== 12'd551) begin failures++; $display("FAIL fr_16_x got=%0d exp=551", bus.xpos_ball); end
    ticks(1);
    checks++; if (bus.xpos_ball !== 12'd554) begin failures++; $display("FAIL fr_speed3_x got=%0d exp=554", bus.xpos_ball); end
    ticks(47);
    checks++; if (bus.xpos_ball !== 12'd647) begin failures++; $display("FAIL fr_64_x got=%0d exp=647", bus.xpos_ball); end
    ticks(5);
    checks++; if (bus.xpos_ball !== 12'd647 || bus.ypos_ball !== 12'd362) begin failures++; $display("FAIL fr_stopped got=(%0d,%0d) exp=(647,362)", bus.xpos_ball, bus.ypos_ball); end
    checks++; if (bus.game_state !== 2'd1) begin failures++; $display("FAIL fr_state got=%0d exp=1", bus.game_state); end
  endtask
`else
  task automatic test_hit_priority();
    to_play();
    set_players(467, 362, 1500, 1500);
    ticks(1);
    checks++; if (bus.xpos_ball !== 12'd491 || bus.ypos_ball !== 12'd362) begin failures++; $display("FAIL hit_p1 got=(%0d,%0d) exp=(491,362)", bus.xpos_ball, bus.ypos_ball); end
    set_players(1500, 1500, 1500, 1500);
    ticks(1);
    checks++; if (bus.xpos_ball !== 12'd495) begin failures++; $display("FAIL hit_vx got=%0d exp=495", bus.xpos_ball); end
    // Both mallets touch; player 1 pushes right, player 2 would push left.
    to_play();
    set_players(467, 362, 507, 362);
    ticks(1);
    checks++; if (bus.xpos_ball !== 12'd491) begin failures++; $display("FAIL both_hit got=%0d exp=491", bus.xpos_ball); end
    set_players(1500, 1500, 1500, 1500);
    ticks(1);
    checks++; if (bus.xpos_ball !== 12'd495 || bus.ypos_ball !== 12'd362) begin failures++; $display("FAIL both_next got=(%0d,%0d) exp=(495,362)", bus.xpos_ball, bus.ypos_ball); end
  endtask

  task automatic test_walls();
    to_play();
    set_players(467, 372, 1500, 1500);
    ticks(1);
    set_players(1500, 1500, 1500, 1500);
    checks++; if (bus.xpos_ball !== 12'd491 || bus.ypos_ball !== 12'd358) begin failures++; $display("FAIL diag_hit got=(%0d,%0d) exp=(491,358)", bus.xpos_ball, bus.ypos_ball); end
    ticks(75);
    checks++; if (bus.xpos_ball !== 12'd791 || bus.ypos_ball !== 12'd58) begin failures++; $display("FAIL top_pre got=(%0d,%0d) exp=(791,58)", bus.xpos_ball, bus.ypos_ball); end
    ticks(1);
    checks++; if (bus.xpos_ball !== 12'd795 || bus.ypos_ball !== 12'd55) begin failures++; $display("FAIL top_clamp got=(%0d,%0d) exp=(795,55)", bus.xpos_ball, bus.ypos_ball); end
    ticks(1);
    checks++; if (bus.xpos_ball !== 12'd799 || bus.ypos_ball !== 12'd59) begin failures++; $display("FAIL top_after got=(%0d,%0d) exp=(799,59)", bus.xpos_ball, bus.ypos_ball); end
    ticks(42);
    checks++; if (bus.xpos_ball !== 12'd967 || bus.ypos_ball !== 12'd227) begin failures++; $display("FAIL right_pre got=(%0d,%0d) exp=(967,227)", bus.xpos_ball, bus.ypos_ball); end
    ticks(1);
    checks++; if (bus.xpos_ball !== 12'd968 || bus.ypos_ball !== 12'd231) begin failures++; $display("FAIL right_clamp got=(%0d,%0d) exp=(968,231)", bus.xpos_ball, bus.ypos_ball); end
    ticks(1);
    checks++; if (bus.xpos_ball !== 12'd964 || bus.ypos_ball !== 12'd235) begin failures++; $display("FAIL right_after got=(%0d,%0d) exp=(964,235)", bus.xpos_ball, bus.ypos_ball); end
    checks++; if (bus.game_state !== 2'd1) begin failures++; $display("FAIL walls_state got=%0d exp=1", bus.game_state); end
  endtask

  task automatic test_goal_left();
    to_play();
    set_players(507, 362, 1500, 1500);
    ticks(1);
    set_players(1500, 1500, 1500, 1500);
    checks++; if (bus.xpos_ball !== 12'd483) begin failures++; $display("FAIL gl_hit got=%0d exp=483", bus.xpos_ball); end
    ticks(107);
    checks++; if (bus.xpos_ball !== 12'd55 || bus.game_state !== 2'd1) begin failures++; $display("FAIL gl_pre got=x%0d s%0d exp=x55 s1", bus.xpos_ball, bus.game_state); end
    // Hold frame_tick high across three cycles: the pulse must still be single.
    @(negedge clk_in);
    bus.frame_tick = 1'b1;
    @(posedge clk_in); #1;
    checks++; if (bus.goal_p2 !== 1'b1 || bus.goal_p1 !== 1'b0) begin failures++; $display("FAIL gl_pulse got=%0b%0b exp=p2", bus.goal_p2, bus.goal_p1); end
    checks++; if (bus.score_p2 !== 4'd1 || bus.score_p1 !== 4'd0) begin failures++; $display("FAIL gl_score got=%0d/%0d exp=0/1", bus.score_p1, bus.score_p2); end
    checks++; if (bus.game_state !== 2'd2 || bus.xpos_ball !== 12'd55) begin failures++; $display("FAIL gl_freeze got=s%0d x%0d exp=s2 x55", bus.game_state, bus.xpos_ball); end
    @(posedge clk_in); #1;
    checks++; if (bus.goal_p2 !== 1'b0) begin failures++; $display("FAIL gl_pulse2 got=%0b exp=0", bus.goal_p2); end
    @(posedge clk_in); #1;
    checks++; if (bus.goal_p2 !== 1'b0 || bus.score_p2 !== 4'd1) begin failures++; $display("FAIL gl_pulse3 got=%0b/%0d exp=0/1", bus.goal_p2, bus.score_p2); end
    bus.frame_tick = 1'b0;
    ticks(57);
    checks++; if (bus.game_state !== 2'd2 || bus.xpos_ball !== 12'd55) begin failures++; $display("FAIL gl_hold got=s%0d x%0d exp=s2 x55", bus.game_state, bus.xpos_ball); end
    ticks(1);
    checks++; if (bus.game_state !== 2'd0) begin failures++; $display("FAIL gl_serve got=%0d exp=0", bus.game_state); end
    checks++; if (bus.xpos_ball !== 12'd487 || bus.ypos_ball !== 12'd362) begin failures++; $display("FAIL gl_recentre got=(%0d,%0d) exp=(487,362)", bus.xpos_ball, bus.ypos_ball); end
  endtask

  task automatic test_goal_right_reset();
    to_play();
    set_players(1500, 1500, 467, 362);
    ticks(1);
    set_players(1500, 1500, 1500, 1500);
    checks++; if (bus.xpos_ball !== 12'd491) begin failures++; $display("FAIL gr_hit got=%0d exp=491", bus.xpos_ball); end
    ticks(119);
    checks++; if (bus.xpos_ball !== 12'd967 || bus.game_state !== 2'd1) begin failures++; $display("FAIL gr_pre got=x%0d s%0d exp=x967 s1", bus.xpos_ball, bus.game_state); end
    ticks(1);
    checks++; if (bus.goal_p1 !== 1'b1 || bus.score_p1 !== 4'd1 || bus.score_p2 !== 4'd0) begin failures++; $display("FAIL gr_goal got=g%0b s%0d/%0d exp=g1 s1/0", bus.goal_p1, bus.score_p1, bus.score_p2); end
    checks++; if (bus.game_state !== 2'd2 || bus.xpos_ball !== 12'd967) begin failures++; $display("FAIL gr_freeze got=s%0d x%0d exp=s2 x967", bus.game_state, bus.xpos_ball); end
    ticks(5);
    do_reset();
    checks++; if (bus.game_state !== 2'd0) begin failures++; $display("FAIL gr_rst_state got=%0d exp=0", bus.game_state); end
    checks++; if (bus.xpos_ball !== 12'd487 || bus.ypos_ball !== 12'd362) begin failures++; $display("FAIL gr_rst_pos got=(%0d,%0d) exp=(487,362)", bus.xpos_ball, bus.ypos_ball); end
    checks++; if (bus.score_p1 !== 4'd0 || bus.score_p2 !== 4'd0 || bus.goal_p1 !== 1'b0 || bus.goal_p2 !== 1'b0) begin failures++; $display("FAIL gr_rst_score got=%0d/%0d g%0b%0b exp=0/0 g00", bus.score_p1, bus.score_p2, bus.goal_p1, bus.goal_p2); end
  endtask
`endif

  initial begin
    bus.frame_tick = 1'b0;
    set_players(1500, 1500, 1500, 1500);
    test_reset();
`ifdef PUCK_FRICTION_EN
    test_friction();
`else
    test_hit_priority();
    test_walls();
    test_goal_left();
    test_goal_right_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/puck_physics_ctl.md
Name: puck_physics_ctl

Overview:
Successor to the single-player ball controller. Moves the puck with a signed velocity vector, updated once per video frame. Handles wall bounces, hits from two players, and goals in both end walls, and keeps score. A SERVE/PLAY/GOAL state machine sequences each rally. It sits between the two player-position controllers and the ball/score draw blocks.

Parameters:
RADIUS_BALL, 10, puck radius in pixels
PLAYERS_RADIUS, 20, player mallet radius in pixels
FIELD_X_MIN, 44, left inner wall x
FIELD_X_MAX, 979, right inner wall x
FIELD_Y_MIN, 44, top inner wall y
FIELD_Y_MAX, 735, bottom inner wall y
GOAL_Y_MIN, 312, goal mouth top y (both end walls)
GOAL_Y_MAX, 412, goal mouth bottom y
X_START, 487, serve x
Y_START, 362, serve y
MAX_SPEED, 4, velocity magnitude per axis after a hit (px/frame), 1..7
SERVE_DELAY, 60, frame ticks spent in SERVE and in GOAL
FRICTION_TICKS, 16, frame ticks per friction step (optional feature only)

Ports:
clk_in  input  1  system clock
rst  input  1  synchronous, active-high reset
frame_tick  input  1  one-cycle pulse per frame; all motion happens only on it
xpos_player_1  input  12  player 1 centre x (defends left goal)
ypos_player_1  input  12  player 1 centre y
xpos_player_2  input  12  player 2 centre x (defends right goal)
ypos_player_2  input  12  player 2 centre y
xpos_ball  output  12  puck centre x
ypos_ball  output  12  puck centre y
score_p1  output  4  player 1 goals scored
score_p2  output  4  player 2 goals scored
goal_p1  output  1  one-cycle pulse: player 1 scored
goal_p2  output  1  one-cycle pulse: player 2 scored
game_state  output  2  0 = SERVE, 1 = PLAY, 2 = GOAL

Behaviour:
- Reset (synchronous, highest priority, also mid-operation):
  - xpos_ball = X_START, ypos_ball = Y_START.
  - vx = vy = 0, both scores = 0, goal pulses = 0.
  - game_state = SERVE, tick counter = 0.
- Only cycles with frame_tick = 1 change state, position, velocity or counters. Inputs are sampled on that cycle; outputs update on the following clk_in edge (one-cycle latency).
- Velocity: vx and vy are 4-bit signed. Position arithmetic uses 13-bit signed intermediates, so no underflow occurs near 0.
- SERVE:
  - Puck is held at (X_START, Y_START) with v = 0.
  - The counter increments per tick. On the tick where the counter equals SERVE_DELAY-1: go to PLAY, clear the counter.
- PLAY, per tick, evaluated in priority order:
  1. Candidate position: nx = x + vx, ny = y + vy.
  2. Left goal: nx-RADIUS_BALL <= FIELD_X_MIN and GOAL_Y_MIN <= ny <= GOAL_Y_MAX. Player 2 scores: score_p2 increments (saturates at 15), goal_p2 pulses, v = 0, puck frozen at current position, go to GOAL. The right goal mirrors this for player 1 (score_p1, goal_p1).
  3. Player hit (player 1 checked first; player 2 only if player 1 did not hit):
     - Hit condition: |nx-xp| <= RADIUS_BALL+PLAYERS_RADIUS and |ny-yp| <= RADIUS_BALL+PLAYERS_RADIUS.
     - New vx = +MAX_SPEED if nx > xp, -MAX_SPEED if nx < xp, -vx if equal. vy uses the same rule on y.
     - Position becomes x + new vx, y + new vy.
  4. Walls, applied to the result of step 3:
     - If x-RADIUS_BALL <= FIELD_X_MIN: x = FIELD_X_MIN+RADIUS_BALL+1, vx = |vx|.
     - If x+RADIUS_BALL >= FIELD_X_MAX: x = FIELD_X_MAX-RADIUS_BALL-1, vx = -|vx|.
     - Y walls are handled the same way with vy.
     - Corner cases clamp both axes in the same tick.
- GOAL:
  - Puck is held; the counter runs for SERVE_DELAY ticks.
  - Then go to SERVE, puck recentred, counter cleared.
- Goal pulses last exactly one clk_in cycle, even if frame_tick stays high on consecutive cycles.
- Velocity never exceeds ±MAX_SPEED. Position never leaves [FIELD_MIN+RADIUS_BALL, FIELD_MAX-RADIUS_BALL] except inside a goal mouth in the GOAL state.

Optional Feature:
PUCK_FRICTION_EN:
- Defined: in PLAY, every FRICTION_TICKS ticks, each non-zero velocity component moves 1 toward 0. The friction counter resets on entry to PLAY and is not applied on hit ticks.
- Undefined: velocity magnitude is constant between hits; the friction counter is not synthesised.

Test Plan:
- Reset, then 59 ticks -> state 0, ball (487,362); tick 60 -> state 1; scores 0.
- PLAY, ball (487,362) v = 0, player 1 at (467,362) -> hit; next tick output ball (491,362), vx = +4, vy = 0.
- Ball (300,56), vy = -4, no players near -> ball y = 55, vy = +4.
- Ball (58,362), vx = -4 -> goal_p2 pulses once, score_p2 = 1, state 2; after 60 ticks state 0, ball (487,362).
- Both players overlapping the puck on the same tick -> only player 1's rule is applied. Reset asserted during GOAL -> all outputs return to their reset values on the next edge.
- PUCK_FRICTION_EN defined, vx = +4 -> after 16 ticks vx = +3; after 64 ticks vx = 0 and the ball is stationary.
